// File: rtl/ahb_arb_pkg.sv
// Shared constants and FSM state type for the two-requester AHB-Lite master arbiter.
// The ARB_TIMEOUT_EN build option uses TIMEOUT_CYC_DEFAULT as its default wait limit.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam int TIMEOUT_CYC_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  function automatic logic is_error(input logic [1:0] resp);
    return resp == HRESP_ERROR;
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// The pointer only advances when gnt_en is high and something is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       gnt_en,
  output logic [1:0] gnt,
  output logic       last_gnt_next
);

  always_comb begin
    gnt           = 2'b00;
    last_gnt_next = last_gnt;
    if (gnt_en) begin
      if (req == 2'b11) begin
        gnt = last_gnt ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
      if (gnt[1]) begin
        last_gnt_next = 1'b1;
      end else if (gnt[0]) begin
        last_gnt_next = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite slave port between two req/done clients, one NONSEQ single at a time.
// Define ARB_TIMEOUT_EN to add a data-phase watchdog of TIMEOUT_CYC wait cycles.
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq0,
  input  logic              iReq1,
  input  logic              iWr0,
  input  logic              iWr1,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWdata0,
  input  logic [DATA_W-1:0] iWdata1,
  output logic              oGnt0,
  output logic              oGnt1,
  output logic              oDone0,
  output logic              oDone1,
  output logic [DATA_W-1:0] oRdata0,
  output logic [DATA_W-1:0] oRdata1,
  output logic              oErr0,
  output logic              oErr1,
  output logic              oHSEL,
  output logic [1:0]        oHTRANS,
  output logic              oHWRITE,
  output logic [ADDR_W-1:0] oHADDR,
  output logic [DATA_W-1:0] oHWDATA,
  input  logic [DATA_W-1:0] iHRDATA,
  input  logic              iHREADY,
  input  logic [1:0]        iHRESP
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hsel_q, hsel_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];

  logic              arb_en;
  logic [1:0]        arb_gnt;
  logic              arb_last_next;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Without the watchdog the wait limit has no effect; keep the parameter referenced.
  if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_unused
  end
`endif

  assign arb_en = (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .req           ({iReq1, iReq0}),
    .last_gnt      (last_q),
    .gnt_en        (arb_en),
    .gnt           (arb_gnt),
    .last_gnt_next (arb_last_next)
  );

  assign sel_wr    = arb_gnt[1] ? iWr1    : iWr0;
  assign sel_addr  = arb_gnt[1] ? iAddr1  : iAddr0;
  assign sel_wdata = arb_gnt[1] ? iWdata1 : iWdata0;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    hsel_d   = hsel_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    err_d    = err_q;
    rdata_d  = rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          state_d  = ST_ADDR;
          last_d   = arb_last_next;
          own_d    = arb_gnt[1];
          wr_d     = sel_wr;
          wdata_d  = sel_wdata;
          hsel_d   = 1'b1;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = sel_wr;
          haddr_d  = sel_addr;
          gnt_d    = arb_gnt;
        end
      end
      ST_ADDR: begin
        if (iHREADY) begin
          state_d  = ST_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          hwrite_d = 1'b0;
          hwdata_d = wr_q ? wdata_q : '0;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_DATA: begin
        // Only the final HREADY=1 cycle carries the response that counts.
        if (iHREADY) begin
          state_d        = ST_DONE;
          done_d[own_q]  = 1'b1;
          err_d[own_q]   = is_error(iHRESP);
          if (!wr_q) begin
            rdata_d[own_q] = iHRDATA;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d        = ST_DONE;
          done_d[own_q]  = 1'b1;
          err_d[own_q]   = 1'b1;
          rdata_d[own_q] = '0;
          hwdata_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        gnt_d    = 2'b00;
        hwdata_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      own_q    <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      hsel_q   <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rdata_q[i] <= '0;
      end
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      own_q    <= own_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      hsel_q   <= hsel_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      for (int i = 0; i < 2; i++) begin
        rdata_q[i] <= rdata_d[i];
      end
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign oGnt0   = gnt_q[0];
  assign oGnt1   = gnt_q[1];
  assign oDone0  = done_q[0];
  assign oDone1  = done_q[1];
  assign oErr0   = err_q[0];
  assign oErr1   = err_q[1];
  assign oRdata0 = rdata_q[0];
  assign oRdata1 = rdata_q[1];
  assign oHSEL   = hsel_q;
  assign oHTRANS = htrans_q;
  assign oHWRITE = hwrite_q;
  assign oHADDR  = haddr_q;
  assign oHWDATA = hwdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed test-plan steps then random transfers,
// checked cycle by cycle against a transaction-level model of grant order and results.
module tb_ahb_master_arbiter;
  import ahb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          hsel, hwrite, hready;
  logic [1:0]    htrans, hresp;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata, hrdata;

  ahb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .iClk(clk), .iRst(rst),
    .iReq0(req0), .iReq1(req1), .iWr0(wr0), .iWr1(wr1),
    .iAddr0(addr0), .iAddr1(addr1), .iWdata0(wdata0), .iWdata1(wdata1),
    .oGnt0(gnt0), .oGnt1(gnt1), .oDone0(done0), .oDone1(done1),
    .oRdata0(rdata0), .oRdata1(rdata1), .oErr0(err0), .oErr1(err1),
    .oHSEL(hsel), .oHTRANS(htrans), .oHWRITE(hwrite), .oHADDR(haddr),
    .oHWDATA(hwdata), .iHRDATA(hrdata), .iHREADY(hready), .iHRESP(hresp)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: who was granted last, and what each requester last got back.
  int            m_last;
  logic [DW-1:0] m_rdata [2];
  logic          m_err   [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, " rdata0"}, rdata0, m_rdata[0]);
    chk({tag, " rdata1"}, rdata1, m_rdata[1]);
    chk({tag, " err"}, {err1, err0}, {m_err[1], m_err[0]});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " bus"}, {hsel, htrans, hwrite}, {1'b0, HTRANS_IDLE, 1'b0});
    chk({tag, " haddr"}, haddr, 0);
    chk({tag, " hwdata"}, hwdata, 0);
    chk({tag, " gnt/done"}, {gnt1, gnt0, done1, done0}, 4'b0000);
    chk_results(tag);
  endtask

  // One complete command: aw/dw are slave wait states in the address/data phase.
  task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input int aw, input int dw, input bit e,
                         input logic [DW-1:0] rd, input string tag);
    int            w;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    own;
    if (r0 && r1) w = (m_last == 0) ? 1 : 0;
    else          w = r1 ? 1 : 0;
    m_last = w;
    wr  = (w == 1) ? w1 : w0;
    a   = (w == 1) ? a1 : a0;
    d   = (w == 1) ? d1 : d0;
    own = (w == 1) ? 2'b10 : 2'b01;
    req0 = r0; req1 = r1; wr0 = w0; wr1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    hready = 1'b1; hresp = HRESP_OKAY;
    @(negedge clk);
    for (int i = 0; i <= aw; i++) begin
      chk({tag, " addr bus"}, {hsel, htrans, hwrite}, {1'b1, HTRANS_NONSEQ, wr});
      chk({tag, " haddr"}, haddr, a);
      chk({tag, " addr gnt/done"}, {gnt1, gnt0, done1, done0}, {own, 2'b00});
      hready = (i == aw);
      @(negedge clk);
    end
    for (int j = 0; j <= dw; j++) begin
      chk({tag, " data bus"}, {hsel, htrans, hwrite}, {1'b0, HTRANS_IDLE, 1'b0});
      chk({tag, " hwdata"}, hwdata, wr ? d : 0);
      chk({tag, " data gnt/done"}, {gnt1, gnt0, done1, done0}, {own, 2'b00});
      hready = (j == dw);
      hrdata = (j == dw) ? rd : $urandom;
      if (j == dw) hresp = e ? HRESP_ERROR : HRESP_OKAY;
      else         hresp = $urandom_range(0, 1) ? HRESP_ERROR : HRESP_OKAY;
      @(negedge clk);
    end
    if (!wr) m_rdata[w] = rd;
    m_err[w] = e;
    chk({tag, " done gnt/done"}, {gnt1, gnt0, done1, done0}, {own, own});
    chk({tag, " done hwdata"}, hwdata, wr ? d : 0);
    chk_results({tag, " done"});
    if (w == 1) req1 = 1'b0; else req0 = 1'b0;
    hready = 1'b1; hresp = HRESP_OKAY;
    @(negedge clk);
    chk({tag, " idle bus"}, {hsel, htrans, hwdata}, {1'b0, HTRANS_IDLE, 32'h0});
    chk({tag, " idle gnt/done"}, {gnt1, gnt0, done1, done0}, 4'b0000);
    $display("txn %s: req=%b%b winner=%0d wr=%0b addr=%h aw=%0d dw=%0d err=%0b",
             tag, r1, r0, w, wr, a, aw, dw, e);
  endtask

  initial begin
    bit r0, r1, rw0, rw1;
    m_last = 1;
    m_rdata[0] = '0; m_rdata[1] = '0;
    m_err[0] = 1'b0; m_err[1] = 1'b0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    hrdata = '0; hready = 1'b1; hresp = HRESP_OKAY;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    run_txn(1, 0, 1, 0, 32'h7000_8000, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, "wr0");
    run_txn(0, 1, 0, 0, 0, 32'h7000_803C, 0, 0, 0, 3, 0, 32'h1234_5678, "rd1_wait3");
    // Both keep requesting: grants must alternate.
    for (int k = 0; k < 4; k++) begin
      run_txn(1, 1, 0, 1, 32'h7000_8100 + k, 32'h7000_8200 + k, 32'hA0 + k, 32'hB0 + k,
              0, k, 0, 32'hC0DE_0000 + k, "both");
    end
    run_txn(1, 0, 0, 0, 32'h7000_9000, 0, 0, 0, 0, 1, 1, 32'h0BAD_0BAD, "rd0_err");

    // Reset while a write is in its data phase: no done, everything back to reset values.
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h7000_A000; wdata0 = 32'h5555_AAAA; req1 = 1'b0;
    hready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid hwdata", hwdata, 32'h5555_AAAA);
    rst = 1'b1; hready = 1'b0;
    m_last = 1;
    m_rdata[0] = '0; m_rdata[1] = '0;
    m_err[0] = 1'b0; m_err[1] = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    rst = 1'b0; req0 = 1'b0; hready = 1'b1;
    @(negedge clk);
    chk("rst_mid no done", {done1, done0}, 2'b00);
    run_txn(0, 1, 1, 1, 0, 32'h7000_B000, 0, 32'h1111_2222, 0, 0, 0, 0, "post_rst1");
    run_txn(1, 1, 0, 0, 32'h7000_C000, 32'h7000_C004, 0, 0, 1, 0, 0, 32'h3333, "post_rst_tie");

    for (int n = 0; n < 40; n++) begin
      r0 = $urandom_range(0, 1);
      r1 = $urandom_range(0, 1);
      if (!r0 && !r1) r0 = 1'b1;
      rw0 = $urandom_range(0, 1);
      rw1 = $urandom_range(0, 1);
      run_txn(r0, r1, rw0, rw1, $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
              $urandom, "rand");
    end

`ifdef ARB_TIMEOUT_EN
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h7000_D000; req1 = 1'b0; hready = 1'b1;
    m_last = 0;
    @(negedge clk);
    @(negedge clk);
    hready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("timeout wait done", {done1, done0}, 2'b00);
      @(negedge clk);
    end
    m_rdata[0] = '0; m_err[0] = 1'b1;
    chk("timeout done", {done1, done0}, 2'b01);
    chk("timeout bus", {hsel, htrans, hwdata}, {1'b0, HTRANS_IDLE, 32'h0});
    chk_results("timeout");
    req0 = 1'b0; hready = 1'b1;
    @(negedge clk);
    chk("timeout idle", {gnt1, gnt0, done1, done0}, 4'b0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Two-requester AHB-Lite master front end that shares the single AHB slave port of Project_Top (AHB-to-APB bridge) between two on-chip clients.
- Accepts simple req/done commands and arbitrates round-robin.
- Sequences each granted command as one NONSEQ single transfer: address phase, then data phase, then waits on HREADY.
- Returns read data and an error flag to the owning requester.

Parameters:
- ADDR_W, 32, address width of requester and AHB address buses.
- DATA_W, 32, data width of write/read data.
- TIMEOUT_CYC, 64, data-phase wait limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset; one clock; reset is synchronous and active-high.
- iReq0/iReq1  in  1  command request; held until matching oDone.
- iWr0/iWr1  in  1  1=write, 0=read; stable while iReqN=1.
- iAddr0/iAddr1  in  ADDR_W  command address; stable while iReqN=1.
- iWdata0/iWdata1  in  DATA_W  write data; stable while iReqN=1.
- oGnt0/oGnt1  out  1  high from address phase until done, for the owning requester.
- oDone0/oDone1  out  1  one-cycle completion pulse.
- oRdata0/oRdata1  out  DATA_W  read data, valid when oDoneN=1, held until next done to the same requester.
- oErr0/oErr1  out  1  valid with oDoneN; 1 if HRESP=ERROR (or timeout).
- oHSEL  out  1  AHB slave select.
- oHTRANS  out  2  AHB transfer type (IDLE=2'b00, NONSEQ=2'b10).
- oHWRITE  out  1  AHB direction.
- oHADDR  out  ADDR_W  AHB address.
- oHWDATA  out  DATA_W  AHB write data.
- iHRDATA  in  DATA_W  AHB read data.
- iHREADY  in  1  bus HREADY (the bridge's HREADYout after the bus mux).
- iHRESP  in  2  AHB response (OKAY=2'b00, ERROR=2'b01).

Behaviour:
- All outputs are registered. Reset values: oHSEL=0, oHTRANS=IDLE, oHWRITE=0, oHADDR=0, oHWDATA=0. All oGnt, oDone, oErr, oRdata are 0. FSM=IDLE. RR pointer=last-granted 1, so requester 0 wins the first tie.
- FSM IDLE -> ADDR: any iReqN=1. Winner is chosen by round-robin.
  - Single request: that requester wins.
  - Both requesting: the requester not granted last wins.
  - Latch winner index, wr, addr, wdata. Next cycle: oHSEL=1, oHTRANS=NONSEQ, oHWRITE, oHADDR driven; oGntN=1.
- FSM ADDR -> DATA: at an edge with iHREADY=1. Otherwise hold address-phase signals.
  - Next cycle: oHSEL=0, oHTRANS=IDLE, oHWRITE=0. oHWDATA=latched wdata (writes) or 0 (reads).
- FSM DATA -> DONE: at an edge with iHREADY=1. Capture iHRDATA into oRdataN (reads only) and (iHRESP==ERROR) into oErrN. Otherwise wait.
- FSM DONE -> IDLE: oDoneN=1 for exactly this cycle. oGntN drops at the DONE exit, and oHWDATA returns to 0.
  - Requester must drop iReqN on the edge ending the done cycle. A request still high in IDLE is a new command.
- Zero-wait latency: request seen at edge E0; done pulse in cycle after E2, i.e. 3 cycles request-to-done. Each slave wait state adds 1 cycle.
- One transfer outstanding at a time. No pipelining of the next address into the current data phase.
- Requests arriving in non-IDLE states are ignored until IDLE.
- A requester dropping iReq mid-transfer does not abort it; done is still pulsed.
- RR pointer updates at grant (IDLE->ADDR) only.
- HRESP=ERROR with iHREADY=0 (first error cycle) is not sampled. Only the final iHREADY=1 cycle counts.
- iRst during ADDR/DATA/DONE: abandon the transfer, no done pulse, all outputs return to reset values the next cycle, pointer reset.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a counter clears on DATA entry and increments each DATA cycle with iHREADY=0. On reaching TIMEOUT_CYC it forces DONE with oErrN=1, oRdataN=0, and the AHB outputs go IDLE.
- Undefined: no counter; DATA waits indefinitely.

Decomposition:
- Package ahb_arb_pkg:
  - HTRANS_IDLE/HTRANS_NONSEQ, HRESP_OKAY/HRESP_ERROR.
  - FSM state enum {IDLE, ADDR, DATA, DONE}, 2-bit encoding.
  - Default TIMEOUT_CYC.
- One sub-module: rr_arb2. Inputs: 2-bit request vector, last-grant pointer, grant enable. Output: one-hot grant and the updated pointer.

Test Plan:
- Req0 write 0x70008000 / 0xDEADBEEF, iHREADY=1 -> one cycle oHSEL=1/NONSEQ/oHWRITE=1/oHADDR=0x70008000. Next cycle oHWDATA=0xDEADBEEF. oDone0 is 3 cycles after request, oErr0=0.
- Req1 read 0x7000803C, slave holds iHREADY=0 for 3 data cycles, then 0x12345678 -> oRdata1=0x12345678 with oDone1 6 cycles after request. No AHB activity during the wait.
- iReq0 and iReq1 both asserted from reset, each re-requesting after done -> grant order 0,1,0,1. Never two consecutive grants to one requester while the other waits.
- Read 0x70009000 with two-cycle ERROR response (iHREADY 0 then 1, iHRESP=01) -> oDone0 with oErr0=1.
- iRst asserted in DATA state of a write -> no oDone pulse. Next cycle oHSEL=0, oHTRANS=00, oHWDATA=0. A fresh req1 is then granted first only if req0 is absent.
- With ARB_TIMEOUT_EN, TIMEOUT_CYC=8, iHREADY stuck 0 in DATA -> oDone with oErr=1 after 8 wait cycles. AHB outputs IDLE.
